// File: rtl/count_checker_pkg.sv
// Shared definitions for the counter checker: event type codes and event field layout.
// An event word is {type[EVT_TYPE_W-1:0], value[W-1:0]} with the type in the MSBs.
package count_checker_pkg;

  localparam int EVT_TYPE_W = 2;

  typedef enum logic [EVT_TYPE_W-1:0] {
    EVT_WRAP  = 2'b01,
    EVT_ERR   = 2'b10,
    EVT_START = 2'b11
  } evt_type_e;

endpackage : count_checker_pkg

// File: rtl/count_checker_if.sv
// Event read-out handshake: the checker (master) offers the head event, the consumer
// (slave) accepts it with evt_ready.
interface count_checker_if #(
  parameter int W = 8
);

  logic           evt_valid;
  logic           evt_ready;
  logic [W+1:0]   evt_data;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );

endinterface : count_checker_if

// File: rtl/count_checker_evt_fifo.sv
// Synchronous FIFO with pointers one bit wider than the address, so full and empty are
// told apart by the extra MSB. A push into a full FIFO only lands if a pop frees a slot.
module evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_eff;
  logic             pop_eff;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  // Head is forced to zero while empty so stale storage never shows on the port.
  assign data_out = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; only the pointers decide what is valid, and
  // leaving the array unreset lets it map onto plain register/RAM cells.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

endmodule : evt_fifo

// File: rtl/count_checker.sv
// Monitor for a free-running counter: checks each sample is the previous one plus one,
// queues START/WRAP/ERR events and keeps wrap/error statistics.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     value,
  count_checker_if.master  evt,
  output logic [15:0]      wrap_count,
  output logic [7:0]       err_count,
  output logic             overflow
);

  localparam int           EW    = W + EVT_TYPE_W;
  localparam logic [W-1:0] W_ONE = 1;

  logic [W-1:0]  prev_q, prev_d;
  logic          primed_q, primed_d;
  logic [15:0]   wrap_count_q, wrap_count_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          overflow_q, overflow_d;

  logic [W-1:0]  exp_value;
  logic          push;
  logic [EW-1:0] push_data;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_data_out;

  assign pop = evt.evt_ready && !fifo_empty;

  // NOTE: every signal assigned in this block gets a default first, so no path through
  // the if/else tree can leave one unassigned and infer a latch.
  always_comb begin
    exp_value    = prev_q + W_ONE;
    push         = 1'b0;
    push_data    = '0;
    prev_d       = value;
    primed_d     = 1'b1;
    wrap_count_d = wrap_count_q;
    err_count_d  = err_count_q;
    overflow_d   = overflow_q;

    if (!primed_q) begin
      push      = 1'b1;
      push_data = {EVT_START, value};
    end else if (value == exp_value) begin
      if (prev_q == '1) begin
        push         = 1'b1;
        push_data    = {EVT_WRAP, value};
        wrap_count_d = wrap_count_q + 16'd1;
      end
    end else begin
      push      = 1'b1;
      push_data = {EVT_ERR, value};
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    // A simultaneous pop frees a slot, so only a push against a stalled full FIFO drops.
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q       <= '0;
      primed_q     <= 1'b0;
      wrap_count_q <= '0;
      err_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      primed_q     <= primed_d;
      wrap_count_q <= wrap_count_d;
      err_count_q  <= err_count_d;
      overflow_q   <= overflow_d;
    end
  end

  evt_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .data_in  (push_data),
    .full     (fifo_full),
    .pop      (pop),
    .data_out (fifo_data_out),
    .empty    (fifo_empty)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_data  = fifo_data_out;
  assign wrap_count    = wrap_count_q;
  assign err_count     = err_count_q;
  assign overflow      = overflow_q;

endmodule : count_checker
